// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, row drive
// patterns, index widths and small decode helpers for the column pattern.
package keypad_pkg;

    // Row and column indices are each two bits; together they form key_code.
    localparam int ROW_W = 2;
    localparam int COL_W = 2;

    // Exactly one row line is pulled low at a time while scanning.
    localparam logic [3:0] ROW0_N    = 4'hE;
    localparam logic [3:0] ROW1_N    = 4'hD;
    localparam logic [3:0] ROW2_N    = 4'hB;
    localparam logic [3:0] ROW3_N    = 4'h7;

    // Column lines idle high through their pull-ups when no key is pressed.
    localparam logic [3:0] COLS_IDLE = 4'hF;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } keypad_state_t;

    // Active-low row drive pattern for a given row index.
    function automatic logic [3:0] rowDrive(input logic [ROW_W-1:0] idx);
        logic [3:0] drive;
        case (idx)
            2'd0:    drive = ROW0_N;
            2'd1:    drive = ROW1_N;
            2'd2:    drive = ROW2_N;
            default: drive = ROW3_N;
        endcase
        return drive;
    endfunction

    // True when exactly one column line is low, i.e. a single unambiguous key.
    function automatic logic oneLow(input logic [3:0] cols);
        logic [2:0] zeros;
        zeros = 3'd0;
        for (int i = 0; i < 4; i++) begin
            zeros = zeros + {2'b00, ~cols[i]};
        end
        return (zeros == 3'd1);
    endfunction

    // Index of the lowest-numbered low column line.
    function automatic logic [COL_W-1:0] colIndex(input logic [3:0] cols);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) begin
                idx = COL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running scan tick divider: asserts tick for one clock out of every
// SCAN_DIV clocks. It never stops, so every FSM state sees the same cadence.
module scan_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Count 0..SCAN_DIV-1 and wrap; the terminal count is the tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (r_count == CNT_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign tick = (r_count == CNT_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce on press and release.
// Rows are driven one at a time (active low); the column lines are
// synchronised and a single-key pattern must stay stable for DEBOUNCE_CNT
// scan ticks before it is accepted. Multi-key patterns are discarded.
// Optional feature: define KEYPAD_REPEAT_EN to emit an auto-repeat key_valid
// every REPEAT_TICKS scan ticks while the accepted key stays down.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 16,
    parameter int REPEAT_TICKS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    // Reject unusable parameter values when the design is elaborated.
    if (SCAN_DIV < 2 || SCAN_DIV > 65535 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_badParams
        $error("keypad_scanner: parameter out of range");
    end

    localparam int DB_W = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);

`ifdef KEYPAD_REPEAT_EN
    localparam int RP_W = (REPEAT_TICKS > 2) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_TICKS - 1);
    logic [RP_W-1:0] r_repCnt;
`endif

    logic [3:0]       r_colMeta;
    logic [3:0]       r_colSync;
    logic [3:0]       w_cols;
    logic             w_colsIdle;
    logic             w_tick;

    keypad_state_t    r_state;
    logic [ROW_W-1:0] r_rowIdx;
    logic [ROW_W-1:0] w_nextRowIdx;
    logic [3:0]       r_rowN;
    logic [3:0]       r_pattern;
    logic [DB_W-1:0]  r_dbCnt;
    logic [3:0]       r_keyCode;
    logic             r_keyValid;
    logic             r_keyHeld;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tickGen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Two-flop synchroniser for the asynchronous column lines; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_colMeta <= COLS_IDLE;
            r_colSync <= COLS_IDLE;
        end else begin
            r_colMeta <= col_n;
            r_colSync <= r_colMeta;
        end
    end

    assign w_cols       = r_colSync;
    assign w_colsIdle   = (w_cols == COLS_IDLE);
    assign w_nextRowIdx = r_rowIdx + ROW_W'(1);

    // Scan/debounce/press/release controller; all decisions are taken on
    // scan ticks, and every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= SCAN;
            r_rowIdx   <= '0;
            r_rowN     <= ROW0_N;
            r_pattern  <= COLS_IDLE;
            r_dbCnt    <= '0;
            r_keyCode  <= '0;
            r_keyValid <= 1'b0;
            r_keyHeld  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_repCnt   <= '0;
`endif
        end else begin
            r_keyValid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (!w_colsIdle) begin
                            r_pattern <= w_cols;
                            r_dbCnt   <= '0;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_rowIdx <= w_nextRowIdx;
                            r_rowN   <= rowDrive(w_nextRowIdx);
                        end
                    end

                    DEBOUNCE: begin
                        // A changed pattern (including release) or a
                        // multi-key pattern abandons this row.
                        if (w_cols != r_pattern || !oneLow(r_pattern)) begin
                            r_state  <= SCAN;
                            r_rowIdx <= w_nextRowIdx;
                            r_rowN   <= rowDrive(w_nextRowIdx);
                        end else if (r_dbCnt == DB_LAST) begin
                            r_state    <= PRESSED;
                            r_keyCode  <= {r_rowIdx, colIndex(r_pattern)};
                            r_keyValid <= 1'b1;
                            r_keyHeld  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            r_repCnt   <= '0;
`endif
                        end else begin
                            r_dbCnt <= r_dbCnt + DB_W'(1);
                        end
                    end

                    PRESSED: begin
                        if (w_colsIdle) begin
                            r_state <= RELEASE;
                            r_dbCnt <= '0;
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (r_repCnt == RP_LAST) begin
                            r_keyValid <= 1'b1;
                            r_repCnt   <= '0;
                        end else begin
                            r_repCnt <= r_repCnt + RP_W'(1);
                        end
`endif
                    end

                    RELEASE: begin
                        // Any low column means the key is still down: go
                        // back without reporting it again.
                        if (!w_colsIdle) begin
                            r_state <= PRESSED;
                        end else if (r_dbCnt == DB_LAST) begin
                            r_state   <= SCAN;
                            r_keyHeld <= 1'b0;
                            r_rowIdx  <= w_nextRowIdx;
                            r_rowN    <= rowDrive(w_nextRowIdx);
                        end else begin
                            r_dbCnt <= r_dbCnt + DB_W'(1);
                        end
                    end

                    default: begin
                        r_state <= SCAN;
                    end
                endcase
            end
        end
    end

    assign row_n     = r_rowN;
    assign key_code  = r_keyCode;
    assign key_valid = r_keyValid;
    assign key_held  = r_keyHeld;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner. A keypad plant model pulls a
// column low only while the pressed key's row is driven, expected key codes
// are queued at press time and a monitor checks each key_valid against them.
// Build with KEYPAD_REPEAT_EN defined to exercise auto-repeat.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int REPEAT_TICKS = 5;
    localparam int LAT_MAX      = 2 + SCAN_DIV * (DEBOUNCE_CNT + 5);
    localparam int HELD_BOUND   = (DEBOUNCE_CNT + 3) * SCAN_DIV;

`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_PULSES  = 1 + 15 / REPEAT_TICKS;
    localparam int HOLD_AFTER  = 2;
`else
    localparam int EXP_PULSES  = 1;
    localparam int HOLD_AFTER  = 15;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic       keyDown = 1'b0;
    logic [1:0] keyRow  = 2'd0;
    logic [3:0] keyCols = 4'hF;

    int         checks     = 0;
    int         errors     = 0;
    int         validCount = 0;
    logic [3:0] expQ[$];
    logic [3:0] monExp;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Keypad plant: the pressed switch connects its row to its column(s).
    always_comb begin
        col_n = 4'hF;
        if (keyDown && row_n[keyRow] == 1'b0) begin
            col_n = keyCols;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic down, input logic [1:0] row, input logic [3:0] cols);
        keyRow  = row;
        keyCols = cols;
        keyDown = down;
    endtask

    task automatic waitValid(input string name);
        int startCount;
        int took;
        startCount = validCount;
        took = 0;
        while (validCount == startCount && took < LAT_MAX + 8) begin
            waitClocks(1);
            took++;
        end
        checks++;
        if (validCount == startCount) begin
            errors++;
            $display("[TB] FAIL %s: no key_valid after %0d clocks, expected one", name, took);
        end else if (took > LAT_MAX + 1) begin
            errors++;
            $display("[TB] FAIL %s: key_valid after %0d clocks, expected at most %0d", name, took, LAT_MAX + 1);
        end
    endtask

    task automatic waitHeldLow(input string name);
        int took;
        took = 0;
        while (key_held && took < HELD_BOUND) begin
            waitClocks(1);
            took++;
        end
        checkOutput(name, key_held, 0);
    endtask

    task automatic countRowChanges(input int clocks, output int changes);
        logic [3:0] prev;
        prev = row_n;
        changes = 0;
        for (int c = 0; c < clocks; c++) begin
            waitClocks(1);
            if (row_n != prev) changes++;
            prev = row_n;
        end
    endtask

    // Monitor: every key_valid must match the next queued expected code.
    always @(negedge clk) begin
        if (rst && key_valid) begin
            validCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got key_code=%0d, expected no key_valid", key_code);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("valid_code", key_code, monExp);
                checkOutput("valid_held", key_held, 1);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int r;
        int c;
        int guard;

        // Reset state.
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 4'hF);
        waitClocks(3);
        checkOutput("rst_row", row_n, 4'hE);
        checkOutput("rst_code", key_code, 0);
        checkOutput("rst_valid", key_valid, 0);
        checkOutput("rst_held", key_held, 0);
        rst = 1'b1;

        // Idle scanning walks rows 0,1,2,3,0 with a SCAN_DIV-clock dwell.
        guard = 0;
        while (row_n == 4'hE && guard < 3 * SCAN_DIV) begin
            waitClocks(1);
            guard++;
        end
        for (int i = 1; i <= 8; i++) begin
            checkOutput("row_seq", row_n, 4'hF ^ (4'h1 << (i % 4)));
            waitClocks(SCAN_DIV);
        end

        // Row 1, column 2 -> code 6, then release.
        expQ.push_back(4'd6);
        applyStimulus(1'b1, 2'd1, 4'hB);
        waitValid("latency_k6");
        waitClocks(HOLD_AFTER * SCAN_DIV);
        checkOutput("held_k6", key_held, 1);
        checkOutput("code_k6", key_code, 6);
        applyStimulus(1'b0, 2'd1, 4'hF);
        waitClocks(2 * SCAN_DIV);
        checkOutput("held_during_release", key_held, 1);
        waitHeldLow("held_low_k6");
        waitClocks(10 * SCAN_DIV);
        checkOutput("code_hold", key_code, 6);

        // Bouncing contact must never be accepted.
        for (int b = 0; b < 12; b++) begin
            applyStimulus((b % 2) == 0, 2'd2, 4'hD);
            waitClocks(SCAN_DIV);
        end
        applyStimulus(1'b0, 2'd2, 4'hF);
        countRowChanges(8 * SCAN_DIV, n);
        checkOutput("bounce_scan_resumes", n >= 6, 1);
        checkOutput("bounce_held", key_held, 0);

        // Two columns low on one row is ambiguous and rejected.
        applyStimulus(1'b1, 2'd2, 4'h9);
        countRowChanges(20 * SCAN_DIV, n);
        checkOutput("multi_row_adv", n >= 8, 1);
        checkOutput("multi_held", key_held, 0);
        applyStimulus(1'b0, 2'd2, 4'hF);
        waitClocks(4 * SCAN_DIV);

        // Random single-key presses.
        for (int k = 0; k < 6; k++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            expQ.push_back(4'(r * 4 + c));
            applyStimulus(1'b1, 2'(r), 4'hF ^ (4'h1 << c));
            waitValid("latency_rand");
            waitClocks(2 * SCAN_DIV + $urandom_range(0, 3));
            applyStimulus(1'b0, 2'(r), 4'hF);
            waitHeldLow("held_low_rand");
            waitClocks($urandom_range(2, 6) * SCAN_DIV);
        end

        // Reset in the middle of a held press aborts it; re-acquired later.
        expQ.push_back(4'd15);
        applyStimulus(1'b1, 2'd3, 4'h7);
        waitValid("latency_k15");
        waitClocks(SCAN_DIV);
        rst = 1'b0;
        waitClocks(2);
        checkOutput("midrst_row", row_n, 4'hE);
        checkOutput("midrst_code", key_code, 0);
        checkOutput("midrst_valid", key_valid, 0);
        checkOutput("midrst_held", key_held, 0);
        expQ.push_back(4'd15);
        rst = 1'b1;
        waitValid("latency_reacquire");
        checkOutput("reacquire_code", key_code, 15);
        applyStimulus(1'b0, 2'd3, 4'hF);
        waitHeldLow("held_low_k15");
        waitClocks(4 * SCAN_DIV);

        // Key 0 held for 16 ticks after acceptance (auto-repeat if built in).
        for (int p = 0; p < EXP_PULSES; p++) expQ.push_back(4'd0);
        applyStimulus(1'b1, 2'd0, 4'hE);
        waitValid("latency_k0");
        waitClocks(16 * SCAN_DIV - 2);
        applyStimulus(1'b0, 2'd0, 4'hF);
        waitHeldLow("held_low_k0");
        waitClocks(6 * SCAN_DIV);

        checkOutput("queue_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
